// File: rtl/irq_ctrl.sv
// irq_ctrl -- eight-source prioritised interrupt controller.
//
// Each SRC bit is synchronised and rising-edge detected into PENDING. When
// the global enable is set and an enabled source is pending, the lowest
// index wins arbitration, is reported on VECTOR and requested on IRQ. The
// core acknowledges with IRQ_ACK (the pending bit is consumed) and signals
// handler return with IRQ_DONE.
//
// Optional feature: define IRQ_CTRL_TIMEOUT_EN to abandon a request that has
// not been acknowledged within 255 cycles; the abandonment is recorded in
// the sticky STATUS.TO bit.
//
// Ports:
//   CLK        in   1  clock, rising edge
//   RESET      in   1  synchronous, active-high reset
//   SRC        in   8  asynchronous interrupt sources, bit 0 highest priority
//   IRQ        out  1  registered interrupt request
//   IRQ_ACK    in   1  core takes the interrupt this cycle
//   IRQ_DONE   in   1  handler has returned
//   CSR_WE     in   1  CSR write strobe
//   CSR_ADDR   in   2  0 ENABLE, 1 PENDING (W1C), 2 CTRL, 3 STATUS
//   CSR_WDATA  in   8  CSR write data
//   CSR_RDATA  out  8  combinational CSR read
//   VECTOR     out  3  source requested / in service
//   BUSY       out  1  high while requesting or in service
module irq_ctrl (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] SRC,
    output logic       IRQ,
    input  logic       IRQ_ACK,
    input  logic       IRQ_DONE,
    input  logic       CSR_WE,
    input  logic [1:0] CSR_ADDR,
    input  logic [7:0] CSR_WDATA,
    output logic [7:0] CSR_RDATA,
    output logic [2:0] VECTOR,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] sync_p0, sync_p1, sync_p2, rise_p3;
    logic [7:0] enable, pending;
    logic       gie;
    logic       to_flag;
    logic [7:0] armed;
    logic       ack_take;
    logic [7:0] clr_mask;

`ifdef IRQ_CTRL_TIMEOUT_EN
    logic [7:0] tmo_cnt;
`endif

    function automatic logic [2:0] lowest_idx(input logic [7:0] req);
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) lowest_idx = i[2:0];
        end
    endfunction

    // Synchroniser (p0, p1), edge reference (p2), registered edge pulse (p3)
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
            rise_p3 <= '0;
        end else begin
            sync_p0 <= SRC;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            rise_p3 <= sync_p1 & ~sync_p2;
        end
    end

    assign armed    = pending & enable;
    assign ack_take = (state == REQ) && IRQ_ACK;

    // Clears from software and from acknowledge; a same-cycle edge wins.
    always_comb begin
        clr_mask = 8'd0;
        if (CSR_WE && CSR_ADDR == 2'd1) clr_mask = clr_mask | CSR_WDATA;
        if (ack_take)                   clr_mask = clr_mask | (8'd1 << VECTOR);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending <= '0;
            enable  <= '0;
            gie     <= 1'b0;
        end else begin
            pending <= (pending & ~clr_mask) | rise_p3;
            if (CSR_WE && CSR_ADDR == 2'd0) enable <= CSR_WDATA;
            if (CSR_WE && CSR_ADDR == 2'd2) gie    <= CSR_WDATA[0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            IRQ     <= 1'b0;
            VECTOR  <= 3'd0;
            to_flag <= 1'b0;
`ifdef IRQ_CTRL_TIMEOUT_EN
            tmo_cnt <= 8'd0;
`endif
        end else begin
`ifdef IRQ_CTRL_TIMEOUT_EN
            if (CSR_WE && CSR_ADDR == 2'd3 && CSR_WDATA[7]) to_flag <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (gie && (armed != 8'd0)) begin
                        VECTOR <= lowest_idx(armed);
                        state  <= REQ;
                        IRQ    <= 1'b1;
`ifdef IRQ_CTRL_TIMEOUT_EN
                        tmo_cnt <= 8'd0;
`endif
                    end
                end
                REQ: begin
                    if (IRQ_ACK) begin
                        state <= SERVICE;
                        IRQ   <= 1'b0;
`ifdef IRQ_CTRL_TIMEOUT_EN
                        tmo_cnt <= 8'd0;
                    end else if (tmo_cnt == 8'd254) begin
                        // 255th unacknowledged cycle: give up, keep PENDING
                        state   <= IDLE;
                        IRQ     <= 1'b0;
                        to_flag <= 1'b1;
                        tmo_cnt <= 8'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
`endif
                    end
                end
                SERVICE: begin
                    if (IRQ_DONE) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    IRQ   <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY = (state != IDLE);

    always_comb begin
        CSR_RDATA = 8'd0;
        case (CSR_ADDR)
            2'd0: CSR_RDATA = enable;
            2'd1: CSR_RDATA = pending;
            2'd2: CSR_RDATA = {7'd0, gie};
            2'd3: CSR_RDATA = {to_flag, 2'b00, state, VECTOR};
            default: CSR_RDATA = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    logic       CLK;
    logic       RESET;
    logic [7:0] SRC;
    logic       IRQ;
    logic       IRQ_ACK;
    logic       IRQ_DONE;
    logic       CSR_WE;
    logic [1:0] CSR_ADDR;
    logic [7:0] CSR_WDATA;
    logic [7:0] CSR_RDATA;
    logic [2:0] VECTOR;
    logic       BUSY;

    int total = 0;
    int bad   = 0;

    irq_ctrl dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SRC       (SRC),
        .IRQ       (IRQ),
        .IRQ_ACK   (IRQ_ACK),
        .IRQ_DONE  (IRQ_DONE),
        .CSR_WE    (CSR_WE),
        .CSR_ADDR  (CSR_ADDR),
        .CSR_WDATA (CSR_WDATA),
        .CSR_RDATA (CSR_RDATA),
        .VECTOR    (VECTOR),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [1:0] raddr;
        logic [7:0] exp;
    } csr_vec_t;

    csr_vec_t vec [7];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic chk_rd(input string name, input logic [1:0] a, input logic [7:0] exp);
        CSR_ADDR = a;
        #1;
        check(name, CSR_RDATA, exp);
    endtask

    task automatic chk_irq(input string name, input logic exp);
        check(name, {7'd0, IRQ}, {7'd0, exp});
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        CSR_WE    = 1'b1;
        CSR_ADDR  = a;
        CSR_WDATA = d;
        tick();
        CSR_WE    = 1'b0;
    endtask

    task automatic ack();
        IRQ_ACK = 1'b1;
        tick();
        IRQ_ACK = 1'b0;
    endtask

    task automatic done();
        IRQ_DONE = 1'b1;
        tick();
        IRQ_DONE = 1'b0;
    endtask

    initial begin
        // {we, addr, wdata, read addr, expected read}
        vec[0] = '{1'b1, 2'd0, 8'hA5, 2'd0, 8'hA5};
        vec[1] = '{1'b1, 2'd2, 8'hFE, 2'd2, 8'h00};
        vec[2] = '{1'b1, 2'd2, 8'h03, 2'd2, 8'h01};
        vec[3] = '{1'b0, 2'd3, 8'h00, 2'd3, 8'h00};
        vec[4] = '{1'b1, 2'd3, 8'hFF, 2'd3, 8'h00};
        vec[5] = '{1'b1, 2'd1, 8'hFF, 2'd1, 8'h00};
        vec[6] = '{1'b1, 2'd0, 8'hFF, 2'd0, 8'hFF};

        RESET = 1'b1; SRC = 8'h00; IRQ_ACK = 1'b0; IRQ_DONE = 1'b0;
        CSR_WE = 1'b0; CSR_ADDR = 2'd0; CSR_WDATA = 8'h00;

        // Reset state
        tick(); tick();
        chk_irq("rst_irq", 1'b0);
        check("rst_busy", {7'd0, BUSY}, 8'h00);
        chk_rd("rst_enable", 2'd0, 8'h00);
        chk_rd("rst_pending", 2'd1, 8'h00);
        chk_rd("rst_status", 2'd3, 8'h00);
        RESET = 1'b0;
        tick();

        // CSR access table
        for (int i = 0; i < 7; i++) begin
            CSR_WE    = vec[i].we;
            CSR_ADDR  = vec[i].addr;
            CSR_WDATA = vec[i].wdata;
            tick();
            CSR_WE = 1'b0;
            chk_rd($sformatf("csr_vec%0d", i), vec[i].raddr, vec[i].exp);
        end

        // Single source: latency, DONE before ACK ignored, GIE drop ignored in REQ
        SRC = 8'h20;
        tick(); tick(); tick();
        chk_rd("s5_pend_e2", 2'd1, 8'h00);
        tick();
        chk_rd("s5_pend_e3", 2'd1, 8'h20);
        chk_irq("s5_irq_e3", 1'b0);
        tick();
        chk_irq("s5_irq_e4", 1'b1);
        check("s5_vector", {5'd0, VECTOR}, 8'h05);
        check("s5_busy", {7'd0, BUSY}, 8'h01);
        chk_rd("s5_status_req", 2'd3, 8'h0D);
        done();
        chk_irq("early_done_irq", 1'b1);
        chk_rd("early_done_status", 2'd3, 8'h0D);
        wr(2'd2, 8'h00);
        chk_irq("gie_off_in_req", 1'b1);
        wr(2'd2, 8'h01);
        ack();
        chk_irq("ack_irq", 1'b0);
        chk_rd("ack_pending", 2'd1, 8'h00);
        chk_rd("ack_status", 2'd3, 8'h15);

        // Re-trigger of the same source during service
        SRC = 8'h00;
        tick(); tick();
        SRC = 8'h20;
        tick(); tick(); tick(); tick();
        chk_rd("svc_repend", 2'd1, 8'h20);
        chk_rd("svc_hold", 2'd3, 8'h15);
        chk_irq("svc_no_irq", 1'b0);
        done();
        chk_rd("ret_status", 2'd3, 8'h05);
        chk_irq("ret_irq", 1'b0);
        tick();
        chk_irq("rereq_irq", 1'b1);
        chk_rd("rereq_status", 2'd3, 8'h0D);
        ack();
        done();
        SRC = 8'h00;

        // Two simultaneous sources: priority order
        SRC = 8'h44;
        tick(); tick(); tick(); tick();
        chk_rd("pri_pend", 2'd1, 8'h44);
        tick();
        chk_rd("pri_first", 2'd3, 8'h0A);
        ack();
        chk_rd("pri_pend_after_ack", 2'd1, 8'h40);
        done();
        chk_rd("pri_idle", 2'd3, 8'h02);
        tick();
        chk_irq("pri_second_irq", 1'b1);
        chk_rd("pri_second", 2'd3, 8'h0E);
        ack();
        chk_rd("pri_pend_empty", 2'd1, 8'h00);
        done();
        chk_rd("pri_done", 2'd3, 8'h06);
        SRC = 8'h00;

        // W1C colliding with an incoming edge, then plain W1C
        wr(2'd2, 8'h00);
        SRC = 8'h08;
        tick(); tick(); tick();
        CSR_WE = 1'b1; CSR_ADDR = 2'd1; CSR_WDATA = 8'h08;
        tick();
        CSR_WE = 1'b0;
        chk_rd("w1c_collide", 2'd1, 8'h08);
        chk_irq("w1c_no_irq", 1'b0);
        wr(2'd1, 8'h08);
        chk_rd("w1c_clear", 2'd1, 8'h00);

        // Disabled source latches but is not arbitrated; then reset in SERVICE
        SRC = 8'h00;
        wr(2'd0, 8'hFD);
        wr(2'd2, 8'h01);
        SRC = 8'h02;
        tick(); tick(); tick(); tick();
        chk_rd("dis_pend", 2'd1, 8'h02);
        tick(); tick();
        chk_irq("dis_no_irq", 1'b0);
        chk_rd("dis_idle", 2'd3, 8'h06);
        wr(2'd0, 8'hFF);
        tick();
        chk_irq("en_irq", 1'b1);
        chk_rd("en_status", 2'd3, 8'h09);
        ack();
        chk_rd("svc1_status", 2'd3, 8'h11);
        RESET = 1'b1;
        SRC = 8'h00;
        tick();
        chk_irq("svc_rst_irq", 1'b0);
        check("svc_rst_busy", {7'd0, BUSY}, 8'h00);
        chk_rd("svc_rst_enable", 2'd0, 8'h00);
        chk_rd("svc_rst_pending", 2'd1, 8'h00);
        chk_rd("svc_rst_ctrl", 2'd2, 8'h00);
        chk_rd("svc_rst_status", 2'd3, 8'h00);
        RESET = 1'b0;
        tick();

        // Long unacknowledged request
        wr(2'd0, 8'hFF);
        wr(2'd2, 8'h01);
        SRC = 8'h80;
        tick(); tick(); tick(); tick();
        chk_rd("long_pend", 2'd1, 8'h80);
        tick();
        chk_irq("long_irq", 1'b1);
        chk_rd("long_status", 2'd3, 8'h0F);
`ifdef IRQ_CTRL_TIMEOUT_EN
        repeat (254) tick();
        chk_irq("tmo_before", 1'b1);
        tick();
        chk_irq("tmo_drop", 1'b0);
        chk_rd("tmo_status", 2'd3, 8'h87);
        chk_rd("tmo_pend_kept", 2'd1, 8'h80);
        tick();
        chk_irq("tmo_rearb", 1'b1);
        chk_rd("tmo_rearb_status", 2'd3, 8'h8F);
        wr(2'd3, 8'h80);
        chk_rd("tmo_clear", 2'd3, 8'h0F);
`else
        repeat (300) tick();
        chk_irq("hold_irq", 1'b1);
        chk_rd("hold_status", 2'd3, 8'h0F);
`endif
        ack();
        done();
        chk_rd("final_status", 2'd3, 8'h07);
        chk_rd("final_pend", 2'd1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
